// File: rtl/vote_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vote_pkg
// Description : Shared types and constants for the 3-of-4 voting round
//               controller: FSM state encoding, voter count, pass threshold,
//               yes-count width and a small popcount helper.
// Revision    : 1.0 - initial release
// ============================================================================
package vote_pkg;

    localparam int N_VOTERS    = 4;
    localparam int THRESH      = 3;
    localparam int c_YES_CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DECIDE  = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Number of set bits in a voter-wide mask.
    function automatic logic [c_YES_CNT_W-1:0] count_ones(input logic [N_VOTERS-1:0] v);
        logic [c_YES_CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < N_VOTERS; i++) begin
            n = n + c_YES_CNT_W'(v[i]);
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vote_threshold.sv
`default_nettype none
// ============================================================================
// Module      : vote_threshold
// Description : Combinational "at least 3 of 4" vote function on a latched
//               ballot (minterms 7, 11, 13, 14, 15; a = ballot[3]).
// Revision    : 1.0 - initial release
// ============================================================================
module vote_threshold
    import vote_pkg::*;
(
    input  logic [N_VOTERS-1:0] i_ballot,
    output logic                o_pass
);

    logic w_a, w_b, w_c, w_d;

    assign w_a = i_ballot[3];
    assign w_b = i_ballot[2];
    assign w_c = i_ballot[1];
    assign w_d = i_ballot[0];

    assign o_pass = (~w_a &  w_b &  w_c &  w_d) |
                    ( w_a & ~w_b &  w_c &  w_d) |
                    ( w_a &  w_b & ~w_c &  w_d) |
                    ( w_a &  w_b &  w_c & ~w_d) |
                    ( w_a &  w_b &  w_c &  w_d);

endmodule
`default_nettype wire

// File: rtl/vote_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vote_round_ctrl
// Description : Voting-round sequencer. Opens a round on start, latches one
//               vote per voter (first vote wins), closes when all four have
//               voted, evaluates the 3-of-4 function and pulses done.
//               Optional macro VOTE_TIMEOUT_EN adds an 8-bit COLLECT timer
//               that closes an incomplete round after TIMEOUT cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module vote_round_ctrl
    import vote_pkg::*;
`ifdef VOTE_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT = 16
)
`endif
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [N_VOTERS-1:0]    vote_valid,
    input  logic [N_VOTERS-1:0]    vote_val,
    output logic                   busy,
    output logic [N_VOTERS-1:0]    voted,
    output logic                   done,
    output logic                   pass,
    output logic [c_YES_CNT_W-1:0] yes_cnt,
    output logic                   timed_out
);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [N_VOTERS-1:0]    r_voted;
    logic [N_VOTERS-1:0]    r_ballot;
    logic [c_YES_CNT_W-1:0] r_yes_cnt;
    logic                   r_pass;
    logic [N_VOTERS-1:0]    w_new;
    logic [N_VOTERS-1:0]    w_new_yes;
    logic [N_VOTERS-1:0]    w_voted_upd;
    logic                   w_complete;
    logic                   w_timeout_hit;
    logic                   w_thr_pass;
    logic                   w_busy;
    logic                   w_done;

    // Votes newly accepted this cycle; already-voted voters are masked off.
    always_comb begin
        w_new       = vote_valid & ~r_voted;
        w_new_yes   = w_new & vote_val;
        w_voted_upd = r_voted | w_new;
        w_complete  = &w_voted_upd;
    end

    vote_threshold u_threshold (
        .i_ballot (r_ballot),
        .o_pass   (w_thr_pass)
    );

`ifdef VOTE_TIMEOUT_EN
    localparam logic [7:0] c_TIMER_LAST = 8'(TIMEOUT - 1);

    logic [7:0] r_timer;
    logic       r_timed_out;

    // Completion on the last timer cycle takes priority over the timeout.
    assign w_timeout_hit = (r_timer == c_TIMER_LAST) && !w_complete;

    // Timer counts COLLECT cycles and is cleared when a round opens.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer <= 8'd0;
        end else if (r_state == IDLE && start) begin
            r_timer <= 8'd0;
        end else if (r_state == COLLECT) begin
            r_timer <= r_timer + 8'd1;
        end
    end

    // Timeout flag is set on the closing edge and held until the next start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timed_out <= 1'b0;
        end else if (r_state == IDLE && start) begin
            r_timed_out <= 1'b0;
        end else if (r_state == COLLECT && w_timeout_hit) begin
            r_timed_out <= 1'b1;
        end
    end

    assign timed_out = r_timed_out;
`else
    assign w_timeout_hit = 1'b0;
    assign timed_out     = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and state-decoded outputs (decoded from the state register only).
    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = COLLECT;
                end
            end
            COLLECT: begin
                w_busy = 1'b1;
                if (w_complete || w_timeout_hit) begin
                    w_state_nxt = DECIDE;
                end
            end
            DECIDE: begin
                w_busy      = 1'b1;
                w_state_nxt = DONE;
            end
            DONE: begin
                w_done      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Ballot, voted mask, yes count and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_voted   <= '0;
            r_ballot  <= '0;
            r_yes_cnt <= '0;
            r_pass    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_voted   <= '0;
                        r_ballot  <= '0;
                        r_yes_cnt <= '0;
                        r_pass    <= 1'b0;
                    end
                end
                COLLECT: begin
                    r_voted   <= w_voted_upd;
                    r_ballot  <= r_ballot | w_new_yes;
                    r_yes_cnt <= r_yes_cnt + count_ones(w_new_yes);
                end
                DECIDE: begin
                    // Missing voters hold a 0 ballot bit, so they count as no.
                    r_pass <= w_thr_pass;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy    = w_busy;
    assign done    = w_done;
    assign voted   = r_voted;
    assign pass    = r_pass;
    assign yes_cnt = r_yes_cnt;

endmodule
`default_nettype wire

// File: tb/tb_vote_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_vote_round_ctrl
// Description : Self-checking bench for vote_round_ctrl. Directed rounds push
//               hand-computed results into a scoreboard queue; a monitor
//               process pops and compares on every done pulse. Timeout
//               scenarios are built when VOTE_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vote_round_ctrl;
    import vote_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] vote_valid;
    logic [3:0] vote_val;
    logic       busy;
    logic [3:0] voted;
    logic       done;
    logic       pass;
    logic [2:0] yes_cnt;
    logic       timed_out;

    logic [3:0] thr_in;
    logic       thr_out;

    int cyc    = 0;
    int errors = 0;
    int checks = 0;
    int n_done = 0;
    int n_exp  = 0;

    typedef struct {
        logic       pass;
        logic [2:0] yes;
        logic       tmo;
        logic [3:0] voted;
        int         done_cyc;
    } exp_t;

    exp_t exp_q[$];

    // Hand-derived: pass for ballots 7, 11, 13, 14, 15; yes count per ballot.
    localparam logic [15:0] c_PASS_TABLE = 16'hE880;
    localparam int c_YES_TABLE [16] = '{0, 1, 1, 2, 1, 2, 2, 3, 1, 2, 2, 3, 2, 3, 3, 4};

    always #5 clk = ~clk;

    // Free-running cycle counter for latency checks.
    always @(posedge clk) cyc <= cyc + 1;

`ifdef VOTE_TIMEOUT_EN
    vote_round_ctrl #(.TIMEOUT(4)) dut (
`else
    vote_round_ctrl dut (
`endif
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .vote_valid (vote_valid),
        .vote_val   (vote_val),
        .busy       (busy),
        .voted      (voted),
        .done       (done),
        .pass       (pass),
        .yes_cnt    (yes_cnt),
        .timed_out  (timed_out)
    );

    vote_threshold u_thr (
        .i_ballot (thr_in),
        .o_pass   (thr_out)
    );

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic start_round(output int ks);
        @(posedge clk); #1;
        start = 1'b1;
        ks    = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic vote(input logic [3:0] vv, input logic [3:0] val);
        vote_valid = vv;
        vote_val   = val;
        @(posedge clk); #1;
        vote_valid = 4'b0000;
        vote_val   = 4'b0000;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic expect_result(input logic p, input logic [2:0] y, input logic t,
                                 input logic [3:0] v, input int dc);
        exp_t e;
        e.pass     = p;
        e.yes      = y;
        e.tmo      = t;
        e.voted    = v;
        e.done_cyc = dc;
        exp_q.push_back(e);
        n_exp++;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && n_done < n_exp; i++) @(posedge clk);
        #1;
        if (n_done < n_exp) chk("done_wait_expired", n_done, n_exp);
    endtask

    // Watchdog: the run must never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int         ks;
        logic [15:0] pt;
        logic [3:0]  pv;
        pt         = c_PASS_TABLE;
        rst        = 1'b1;
        start      = 1'b0;
        vote_valid = 4'b0000;
        vote_val   = 4'b0000;
        thr_in     = 4'b0000;

        // Monitor: pops the scoreboard on every done pulse; checks invariant.
        fork
            forever begin
                exp_t e;
                @(negedge clk);
                if (!rst && !busy) begin
                    checks++;
                    assert (pass == (yes_cnt >= 3'(THRESH)))
                    else begin
                        errors++;
                        $display("FAIL invariant: pass=%0d yes_cnt=%0d (cycle %0d)", pass, yes_cnt, cyc);
                    end
                end
                if (!rst && done) begin
                    n_done++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("done_cycle", cyc, e.done_cyc);
                        chk("pass", int'(pass), int'(e.pass));
                        chk("yes_cnt", int'(yes_cnt), int'(e.yes));
                        chk("timed_out", int'(timed_out), int'(e.tmo));
                        chk("voted", int'(voted), int'(e.voted));
                        chk("busy_in_done", int'(busy), 0);
                    end
                end
            end
        join_none

        // Exhaustive unit sweep of the threshold function.
        for (int p = 0; p < 16; p++) begin
            thr_in = 4'(p);
            #1;
            chk("threshold_unit", int'(thr_out), int'(pt[p]));
        end

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_voted", int'(voted), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_pass", int'(pass), 0);
        chk("rst_yes_cnt", int'(yes_cnt), 0);
        chk("rst_timed_out", int'(timed_out), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1. Reset in the middle of COLLECT.
        start_round(ks);
        vote(4'b0011, 4'b0011);
        chk("mid_voted", int'(voted), 3);
        chk("mid_yes_cnt", int'(yes_cnt), 2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_voted", int'(voted), 0);
        chk("midrst_yes_cnt", int'(yes_cnt), 0);
        chk("midrst_pass", int'(pass), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_timed_out", int'(timed_out), 0);
        start_round(ks);
        chk("clean_busy", int'(busy), 1);
        chk("clean_voted", int'(voted), 0);
        chk("clean_yes_cnt", int'(yes_cnt), 0);

        // 2. Simultaneous full vote, ballot 1011.
        expect_result(1'b1, 3'd3, 1'b0, 4'b1111, cyc + 2);
        vote(4'b1111, 4'b1011);
        wait_done();

        // 3. Staggered votes with a changed repeat from voter 2.
        start_round(ks);
        vote(4'b0100, 4'b0100);
        vote(4'b0111, 4'b0000);
        expect_result(1'b0, 3'd2, 1'b0, 4'b1111, cyc + 2);
        vote(4'b1000, 4'b1000);
        wait_done();

`ifdef VOTE_TIMEOUT_EN
        // 4. Timeout with voter 0 missing (TIMEOUT = 4).
        start_round(ks);
        expect_result(1'b1, 3'd3, 1'b1, 4'b1110, ks + 6);
        vote(4'b1110, 4'b1110);
        wait_done();

        // 5. Last voter arrives exactly on the timeout edge: completion wins.
        start_round(ks);
        vote(4'b1110, 4'b1110);
        idle(2);
        expect_result(1'b1, 3'd4, 1'b0, 4'b1111, ks + 6);
        vote(4'b0001, 4'b0001);
        wait_done();
`else
        // Without the timer an incomplete round waits indefinitely.
        start_round(ks);
        vote(4'b0111, 4'b0111);
        idle(20);
        chk("notimer_busy", int'(busy), 1);
        chk("notimer_timed_out", int'(timed_out), 0);
        chk("notimer_voted", int'(voted), 7);
        expect_result(1'b1, 3'd3, 1'b0, 4'b1111, cyc + 2);
        vote(4'b1000, 4'b0000);
        wait_done();
`endif

        // 6. All ballot patterns; start asserted in DONE must be ignored.
        for (int p = 0; p < 16; p++) begin
            pv = 4'(p);
            start_round(ks);
            expect_result(pt[p], 3'(c_YES_TABLE[p]), 1'b0, 4'b1111, cyc + 2);
            vote(4'b1111, pv);
            idle(1);
            start = 1'b1;
            idle(1);
            start = 1'b0;
            @(negedge clk);
            chk("start_in_done_ignored", int'(busy), 0);
            wait_done();
        end

        idle(2);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vote_round_ctrl.md
Name: vote_round_ctrl

Overview:
Sequencer for the 4-input "at least 3 of 4" vote function (minterms 7, 11, 13, 14, 15).
- Opens a voting round on `start` and collects one vote per voter over time. Voters may respond on different cycles.
- Closes the round when all 4 have voted, or on timeout.
- Evaluates the threshold function on the latched ballot and reports the result with a done pulse.
- Sits between independent requester agents and the shared vote-evaluation logic.

Parameters:
- N_VOTERS, 4, number of voters; fixed at 4 for this revision.
- THRESH, 3, minimum yes count for pass; must match the 3-of-4 function.
- TIMEOUT, 16, maximum COLLECT cycles per round (only with VOTE_TIMEOUT_EN); range 2..255.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request to open a round; honoured only in IDLE.
- vote_valid  in  4  per-voter strobe; bit i means voter i presents a vote this cycle.
- vote_val  in  4  per-voter vote value (1 = yes); sampled only when the matching vote_valid bit is 1.
- busy  out  1  high in COLLECT and DECIDE.
- voted  out  4  bit i set once voter i's vote is latched this round.
- done  out  1  one-cycle pulse when the result is valid.
- pass  out  1  result: yes_cnt >= THRESH; held until the next start.
- yes_cnt  out  3  number of yes votes latched (0..4); held until the next start.
- timed_out  out  1  round closed by timeout; held until the next start.

Behaviour:
- Reset (synchronous, active-high) overrides everything, including mid-round:
  - state = IDLE.
  - busy, voted, done, pass, yes_cnt, timed_out, ballot register and timer all = 0.
- IDLE:
  - start=1 → COLLECT next cycle.
  - On the same edge: clear voted, ballot, yes_cnt, pass, timed_out; timer = 0.
  - vote_valid is ignored in IDLE.
- COLLECT:
  - Each cycle, for each bit i with vote_valid[i]=1 and voted[i]=0: set voted[i] and ballot[i]=vote_val[i]. yes_cnt increments by the number of newly latched yes votes.
  - Multiple voters may vote in the same cycle.
  - First vote wins: repeat strobes from an already-voted voter are ignored, even if the value differs.
  - start is ignored.
  - Go to DECIDE when the updated voted mask = 4'b1111. Votes arriving on that edge are included.
- DECIDE (1 cycle):
  - Missing voters count as no.
  - pass <= f(ballot), where f = a'bcd + ab'cd + abc'd + abcd' + abcd, with a = ballot[3] … d = ballot[0].
  - Go to DONE.
- DONE (1 cycle):
  - done=1, busy=0.
  - Go to IDLE.
  - start in DONE is ignored; the requester must reassert it in IDLE.
- Latency: last vote latched on edge t → DECIDE during cycle t+1 → done high during cycle t+2.
- Invariant: pass == (yes_cnt >= THRESH). The bench checks this as an assertion.
- Outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: VOTE_TIMEOUT_EN.
- Defined:
  - An 8-bit timer counts COLLECT cycles.
  - When timer = TIMEOUT-1 and the mask is still incomplete after this cycle's votes, go to DECIDE and set timed_out=1.
  - Votes on the timeout edge are counted.
  - If the mask completes on the same edge, completion wins: timed_out=0.
- Undefined:
  - No timer; COLLECT waits indefinitely for all 4 voters.
  - timed_out is tied to 0 (port kept).

Decomposition:
- Package vote_pkg holds:
  - state typedef {IDLE, COLLECT, DECIDE, DONE}.
  - N_VOTERS and THRESH constants.
  - Width constant for yes_cnt.
- Sub-module vote_threshold: purely combinational, 4-bit ballot → 1-bit pass, implementing the 3-of-4 SOP.
  - Instantiated once in DECIDE logic.
  - Unit-tested exhaustively over all 16 inputs.

Test Plan:
1. Reset mid-COLLECT: start; voters 0, 1 vote yes; rst=1 for one cycle → all outputs 0, state IDLE; a subsequent start opens a clean round.
2. Simultaneous full vote: start; next cycle vote_valid=1111, vote_val=1011 → done 2 cycles later, yes_cnt=3, pass=1, timed_out=0.
3. Staggered votes with repeats:
   - Voter 2 yes at cycle 1; voter 2 re-votes no at cycle 2 (ignored).
   - Voters 0, 1 no; voter 3 yes.
   - Expected: yes_cnt=2, pass=0, voted=1111.
4. Timeout (macro defined, TIMEOUT=4): only voters 1, 2, 3 vote yes by cycle 1 → DECIDE after 4 COLLECT cycles, timed_out=1, yes_cnt=3, pass=1.
5. Timeout/completion race (macro defined): last voter votes exactly on the timeout edge → timed_out=0; vote counted.
6. Exhaustive ballot sweep: all 16 vote_val patterns, one full round each → pass=1 only for patterns 0111, 1011, 1101, 1110, 1111; start asserted in DONE is ignored.
